frame_update_arbiter: RTL and testbench
=======================================

FRAME_UPDATE_ARBITER -- requirements
Module: frame_update_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters; legal range 2..8.
REQ-002 Parameter TIMEOUT, default 64: grant watchdog limit in clk cycles; legal range 2..1023.
REQ-003 clk  input  1  pixel clock; the only clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 vblnk_in  input  1  vertical blanking from the VGA timing chain; updates are permitted only while it is high.
REQ-006 req  input  N_REQ  per-requester update request; level-sensitive.
REQ-007 done  input  N_REQ  per-requester completion strobe; one cycle.
REQ-008 grant  output  N_REQ  one-hot or zero; registered.
REQ-009 frame_tick  output  1  one-cycle pulse at the start of each vertical blank; registered.
REQ-010 aborted  output  1  one-cycle pulse when a grant is revoked by the end of vblank; registered.
REQ-011 timeout_err  output  1  sticky watchdog flag; registered.
REQ-012 frame_cnt  output  8  frame counter; registered.

Function
REQ-013 A registered copy vblnk_d SHALL be kept; vblank rise is vblnk_in=1 while vblnk_d=0, and vblank fall is vblnk_in=0 while vblnk_d=1.
REQ-014 On a vblank rise the block SHALL, on the same edge:
  - set frame_tick=1 for exactly one cycle;
  - increment frame_cnt modulo 256 (255 wraps to 0);
  - clear the served mask;
  - enter state ARB.
REQ-015 States SHALL be IDLE, ARB and GRANT; grant SHALL be 0 in IDLE and ARB.
REQ-016 IDLE: the block SHALL wait for a vblank rise; req and done are ignored.
REQ-017 ARB with vblnk_in=0: the next state SHALL be IDLE.
REQ-018 ARB with vblnk_in=1: the block SHALL select the first requester i, searching from the priority pointer upward modulo N_REQ, with req[i]=1 and served[i]=0.
  - If one is found, the next edge SHALL give grant=one-hot(i) and state GRANT, so grant follows a visible req by 1 cycle.
  - If none is found, the block SHALL stay in ARB.
REQ-019 GRANT with done[i]=1 for the granted i: the next edge SHALL set grant=0 and served[i]=1, set the pointer to (i+1) mod N_REQ, and return to ARB.
REQ-020 done on a non-granted line SHALL be ignored; deasserting req while granted SHALL NOT revoke the grant.
REQ-021 GRANT with a vblank fall and no done: the next edge SHALL set grant=0 and aborted=1 for one cycle, go to IDLE, and leave the pointer and served unchanged.
REQ-022 GRANT with done and a vblank fall in the same cycle: done SHALL win. served and the pointer update, aborted stays 0, and the state goes to IDLE.
REQ-023 Each requester SHALL receive at most one grant per vblank period.
REQ-024 A vblank rise seen while in GRANT cannot occur; the block SHALL treat it as in REQ-014 and drop grant.

Reset
REQ-025 While rst=0 the block SHALL hold:
  - grant=0, frame_tick=0, aborted=0, timeout_err=0, frame_cnt=0;
  - pointer=0, served=0, vblnk_d=0, watchdog count=0;
  - state IDLE.
REQ-026 After release, if vblnk_in is already 1 on the first edge, that edge SHALL count as a vblank rise.
REQ-027 Reset asserted mid-grant SHALL drop grant immediately (asynchronously), with no aborted pulse.

Configuration
REQ-028 Macro FRAME_UPDATE_WATCHDOG_EN SHALL compile in a grant watchdog.
REQ-029 With FRAME_UPDATE_WATCHDOG_EN defined:
  - a counter SHALL clear on entry to GRANT and increment each GRANT cycle;
  - when it equals TIMEOUT-1 with no done and no vblank fall, the next edge SHALL set grant=0, set served[i]=1, advance the pointer, set timeout_err=1 (sticky until reset), and go to ARB;
  - done and a vblank fall SHALL take precedence over the watchdog in the same cycle.
REQ-030 Without the macro, the counter logic SHALL NOT exist, timeout_err SHALL be constant 0, and a grant is held until done or a vblank fall.

Verification
REQ-031 Reset, then vblnk_in 0->1 -> frame_tick pulses 1 cycle, frame_cnt=1, grant=0.
REQ-032 N_REQ=4, req=4'b1111 held, each granted line answers done 3 cycles after its grant -> grant sequence 0001,0010,0100,1000, then 0000 for the rest of vblank; the next frame starts again at 0001 (pointer=0).
REQ-033 req=4'b0100 only, no done, vblnk_in falls 10 cycles after grant -> grant=0 and aborted=1 on the next edge, state IDLE; the next frame grants 0100 again.
REQ-034 done[2] and the vblank fall in the same cycle while granted to 2 -> aborted stays 0, the pointer becomes 3, served[2] is set.
REQ-035 WATCHDOG_EN, TIMEOUT=8, req=4'b0001, done never asserted -> grant drops after 8 GRANT cycles, timeout_err=1 and stays 1 across frames until rst=0.
REQ-036 257 vblank rises -> frame_cnt wraps and reads 1; rst=0 mid-grant -> grant=0 without waiting for clk.

Source files
------------

// File: rtl/frame_update_arbiter.sv
// Vblank-gated round-robin arbiter granting frame-buffer update slots, one per requester per frame.
// Define FRAME_UPDATE_WATCHDOG_EN to compile in a grant watchdog that revokes stalled grants.
module frame_update_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vblnk_in,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] done,
  output logic [N_REQ-1:0] grant,
  output logic             frame_tick,
  output logic             aborted,
  output logic             timeout_err,
  output logic [7:0]       frame_cnt
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned SUM_W = IDX_W + 1;

  typedef enum logic [1:0] {IDLE, ARB, GRANT} state_t;

  state_t           state_q, state_n;
  logic             vblnk_d;
  logic             rise, fall;
  logic [IDX_W-1:0] ptr_q, ptr_n;
  logic [IDX_W-1:0] gidx_q, gidx_n, gidx_inc, pick;
  logic [N_REQ-1:0] served_q, served_n;
  logic [N_REQ-1:0] grant_n, cand, cand_rot;
  logic [SUM_W-1:0] off, sum;
  logic             found, done_hit;
  logic             tick_n, abort_n;
  logic [7:0]       cnt_n;

`ifdef FRAME_UPDATE_WATCHDOG_EN
  localparam int unsigned WD_W = 10;
  logic [WD_W-1:0] wd_q, wd_n;
  logic            terr_n, wd_expired;
  assign wd_expired = (wd_q == WD_W'(TIMEOUT - 1));
`endif

  assign rise = vblnk_in & ~vblnk_d;
  assign fall = ~vblnk_in & vblnk_d;

  // Candidates rotated so bit 0 is the requester at the priority pointer.
  assign cand     = req & ~served_q;
  assign cand_rot = N_REQ'({cand, cand} >> ptr_q);

  always_comb begin : pick_first
    found = 1'b0;
    off   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (cand_rot[k[IDX_W-1:0]]) begin
        found = 1'b1;
        off   = SUM_W'(k);
      end
    end
  end

  assign sum      = SUM_W'(ptr_q) + off;
  assign pick     = (sum >= SUM_W'(N_REQ)) ? IDX_W'(sum - SUM_W'(N_REQ)) : IDX_W'(sum);
  assign gidx_inc = (gidx_q == IDX_W'(N_REQ - 1)) ? '0 : gidx_q + IDX_W'(1);
  assign done_hit = |(done & grant);

  always_comb begin : next_state
    state_n  = state_q;
    ptr_n    = ptr_q;
    served_n = served_q;
    gidx_n   = gidx_q;
    grant_n  = grant;
    tick_n   = 1'b0;
    abort_n  = 1'b0;
    cnt_n    = frame_cnt;
`ifdef FRAME_UPDATE_WATCHDOG_EN
    wd_n     = wd_q;
    terr_n   = timeout_err;
`endif
    if (rise) begin
      // New frame: restart the served set, keep the pointer for fairness across frames.
      state_n  = ARB;
      tick_n   = 1'b1;
      cnt_n    = frame_cnt + 8'd1;
      served_n = '0;
      grant_n  = '0;
    end else begin
      case (state_q)
        IDLE: state_n = IDLE;
        ARB: begin
          if (!vblnk_in) begin
            state_n = IDLE;
          end else if (found) begin
            state_n = GRANT;
            gidx_n  = pick;
            grant_n = N_REQ'(1) << pick;
`ifdef FRAME_UPDATE_WATCHDOG_EN
            wd_n    = '0;
`endif
          end
        end
        GRANT: begin
          if (done_hit) begin
            grant_n  = '0;
            served_n = served_q | grant;
            ptr_n    = gidx_inc;
            state_n  = fall ? IDLE : ARB;
          end else if (fall) begin
            grant_n = '0;
            abort_n = 1'b1;
            state_n = IDLE;
          end
`ifdef FRAME_UPDATE_WATCHDOG_EN
          else if (wd_expired) begin
            grant_n  = '0;
            served_n = served_q | grant;
            ptr_n    = gidx_inc;
            terr_n   = 1'b1;
            state_n  = ARB;
          end else begin
            wd_n = wd_q + WD_W'(1);
          end
`endif
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin : state_reg
    if (!rst) state_q <= IDLE;
    else      state_q <= state_n;
  end

  always_ff @(posedge clk or negedge rst) begin : data_regs
    if (!rst) begin
      vblnk_d    <= 1'b0;
      grant      <= '0;
      frame_tick <= 1'b0;
      aborted    <= 1'b0;
      frame_cnt  <= '0;
      ptr_q      <= '0;
      gidx_q     <= '0;
      served_q   <= '0;
    end else begin
      vblnk_d    <= vblnk_in;
      grant      <= grant_n;
      frame_tick <= tick_n;
      aborted    <= abort_n;
      frame_cnt  <= cnt_n;
      ptr_q      <= ptr_n;
      gidx_q     <= gidx_n;
      served_q   <= served_n;
    end
  end

`ifdef FRAME_UPDATE_WATCHDOG_EN
  always_ff @(posedge clk or negedge rst) begin : wd_regs
    if (!rst) begin
      wd_q        <= '0;
      timeout_err <= 1'b0;
    end else begin
      wd_q        <= wd_n;
      timeout_err <= terr_n;
    end
  end
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_frame_update_arbiter.sv
// Self-checking bench for frame_update_arbiter: vector table, directed corner sequences,
// and randomized traffic against a behavioural frame/served-set model.
module tb_frame_update_arbiter;

  localparam int N = 4;
`ifdef FRAME_UPDATE_WATCHDOG_EN
  localparam int TO = 8;
  localparam bit WD = 1'b1;
`else
  localparam int TO = 64;
  localparam bit WD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       vb;
  logic [3:0] req, done, grant;
  logic       frame_tick, aborted, timeout_err;
  logic [7:0] frame_cnt;

  int checks = 0;
  int errors = 0;

  frame_update_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .vblnk_in(vb), .req(req), .done(done),
    .grant(grant), .frame_tick(frame_tick), .aborted(aborted),
    .timeout_err(timeout_err), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: who holds the slot this frame, who has been served, next in line.
  bit       m_vbd, m_active, m_tick, m_ab, m_terr;
  bit [3:0] m_served;
  int       m_g, m_ptr, m_frame, m_wdc;

  function automatic bit bit_at(input logic [3:0] v, input int i);
    return v[i[1:0]];
  endfunction

  task automatic model_reset();
    m_vbd = 0; m_active = 0; m_tick = 0; m_ab = 0; m_terr = 0;
    m_served = '0; m_g = -1; m_ptr = 0; m_frame = 0; m_wdc = 0;
  endtask

  task automatic model_step();
    bit r, f;
    r = vb && !m_vbd;
    f = !vb && m_vbd;
    m_tick = 0;
    m_ab = 0;
    if (r) begin
      m_tick = 1; m_frame = (m_frame + 1) % 256; m_served = '0; m_active = 1; m_g = -1;
    end else if (m_g >= 0) begin
      if (bit_at(done, m_g)) begin
        m_served = m_served | (4'b1 << m_g); m_ptr = (m_g + 1) % N; m_g = -1; m_active = vb;
      end else if (f) begin
        m_ab = 1; m_g = -1; m_active = 0;
      end else if (WD && m_wdc == TO - 1) begin
        m_served = m_served | (4'b1 << m_g); m_ptr = (m_g + 1) % N; m_g = -1; m_terr = 1;
      end else begin
        m_wdc++;
      end
    end else if (m_active) begin
      if (!vb) m_active = 0;
      else begin
        for (int k = 0; k < N; k++) begin
          int i;
          i = (m_ptr + k) % N;
          if (bit_at(req, i) && !m_served[i[1:0]]) begin
            m_g = i; m_wdc = 0; break;
          end
        end
      end
    end
    m_vbd = vb;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic v, input logic [3:0] r, input logic [3:0] d);
    vb = v; req = r; done = d;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic v);
    rst = 1'b0; vb = v; req = '0; done = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", 32'({grant, frame_tick, aborted, timeout_err, frame_cnt}), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic       v;
    logic [3:0] r, d, g;
    logic       t, a;
    logic [7:0] c;
  } vec_t;
  vec_t tbl[21];

  logic [3:0] exp_g;
  logic       vcur;
  int         held;

  initial begin
    tbl[0]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'd0};
    tbl[1]  = '{1'b1, 4'b0100, 4'b0000, 4'b0000, 1'b1, 1'b0, 8'd1};
    tbl[2]  = '{1'b1, 4'b0100, 4'b0000, 4'b0100, 1'b0, 1'b0, 8'd1};
    tbl[3]  = '{1'b1, 4'b0100, 4'b0000, 4'b0100, 1'b0, 1'b0, 8'd1};
    tbl[4]  = '{1'b1, 4'b0000, 4'b0000, 4'b0100, 1'b0, 1'b0, 8'd1};
    tbl[5]  = '{1'b1, 4'b0000, 4'b0001, 4'b0100, 1'b0, 1'b0, 8'd1};
    tbl[6]  = '{1'b0, 4'b0100, 4'b0000, 4'b0000, 1'b0, 1'b1, 8'd1};
    tbl[7]  = '{1'b0, 4'b0100, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'd1};
    tbl[8]  = '{1'b1, 4'b0100, 4'b0000, 4'b0000, 1'b1, 1'b0, 8'd2};
    tbl[9]  = '{1'b1, 4'b0100, 4'b0000, 4'b0100, 1'b0, 1'b0, 8'd2};
    tbl[10] = '{1'b1, 4'b0100, 4'b0100, 4'b0000, 1'b0, 1'b0, 8'd2};
    tbl[11] = '{1'b1, 4'b0110, 4'b0000, 4'b0010, 1'b0, 1'b0, 8'd2};
    tbl[12] = '{1'b1, 4'b0110, 4'b0010, 4'b0000, 1'b0, 1'b0, 8'd2};
    tbl[13] = '{1'b1, 4'b0110, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'd2};
    tbl[14] = '{1'b1, 4'b0110, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'd2};
    tbl[15] = '{1'b0, 4'b0110, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'd2};
    tbl[16] = '{1'b1, 4'b1111, 4'b0000, 4'b0000, 1'b1, 1'b0, 8'd3};
    tbl[17] = '{1'b1, 4'b1111, 4'b0000, 4'b0100, 1'b0, 1'b0, 8'd3};
    tbl[18] = '{1'b0, 4'b1111, 4'b0100, 4'b0000, 1'b0, 1'b0, 8'd3};
    tbl[19] = '{1'b1, 4'b1111, 4'b0000, 4'b0000, 1'b1, 1'b0, 8'd4};
    tbl[20] = '{1'b1, 4'b1111, 4'b0000, 4'b1000, 1'b0, 1'b0, 8'd4};

    // Vector table: abort on fall, done-on-fall, pointer rotation, served blocking.
    do_reset(1'b0);
    for (int i = 0; i < 21; i++) begin
      step(tbl[i].v, tbl[i].r, tbl[i].d);
      check($sformatf("vec%0d", i), 32'({grant, frame_tick, aborted, frame_cnt}),
            32'({tbl[i].g, tbl[i].t, tbl[i].a, tbl[i].c}));
    end

    // Vblank already high when reset releases counts as a rise.
    do_reset(1'b1);
    step(1'b1, 4'b0000, 4'b0000);
    check("rise_at_release", 32'({frame_tick, frame_cnt}), 32'({1'b1, 8'd1}));

    // All four requesting, done three cycles after each grant: strict round robin.
    do_reset(1'b0);
    step(1'b0, 4'b1111, 4'b0000);
    step(1'b1, 4'b1111, 4'b0000);
    for (int l = 0; l < 4; l++) begin
      step(1'b1, 4'b1111, 4'b0000);
      check($sformatf("rr_grant%0d", l), 32'(grant), 32'(4'b0001 << l));
      step(1'b1, 4'b1111, 4'b0000);
      step(1'b1, 4'b1111, 4'b0000);
      step(1'b1, 4'b1111, grant);
      check($sformatf("rr_release%0d", l), 32'(grant), 32'd0);
    end
    held = 0;
    for (int k = 0; k < 6; k++) begin
      step(1'b1, 4'b1111, 4'b0000);
      if (grant != 4'b0000) held++;
    end
    check("rr_no_second_grant", 32'(held), 32'd0);
    step(1'b0, 4'b1111, 4'b0000);
    step(1'b1, 4'b1111, 4'b0000);
    step(1'b1, 4'b1111, 4'b0000);
    check("rr_next_frame", 32'(grant), 32'(4'b0001));

    // 257 frames wrap the counter to 1.
    do_reset(1'b0);
    for (int f = 0; f < 257; f++) begin
      step(1'b0, 4'b0000, 4'b0000);
      step(1'b1, 4'b0000, 4'b0000);
      if (f == 0) check("first_tick", 32'({frame_tick, frame_cnt, grant}), 32'({1'b1, 8'd1, 4'b0000}));
    end
    check("frame_wrap", 32'(frame_cnt), 32'd1);
    step(1'b1, 4'b0000, 4'b0000);
    check("tick_one_cycle", 32'(frame_tick), 32'd0);

    // Reset mid-grant drops grant before the next clock edge.
    do_reset(1'b0);
    step(1'b0, 4'b0100, 4'b0000);
    step(1'b1, 4'b0100, 4'b0000);
    step(1'b1, 4'b0100, 4'b0000);
    check("pre_async_grant", 32'(grant), 32'(4'b0100));
    #2;
    rst = 1'b0;
    #1;
    check("async_reset_drop", 32'({grant, aborted}), 32'd0);

`ifdef FRAME_UPDATE_WATCHDOG_EN
    // Stalled grant is revoked after TO cycles; error flag is sticky.
    do_reset(1'b0);
    step(1'b0, 4'b0001, 4'b0000);
    step(1'b1, 4'b0001, 4'b0000);
    step(1'b1, 4'b0001, 4'b0000);
    held = (grant == 4'b0001) ? 1 : 0;
    for (int k = 0; k < 30 && grant != 4'b0000; k++) begin
      step(1'b1, 4'b0001, 4'b0000);
      if (grant == 4'b0001) held++;
    end
    check("wd_hold_cycles", 32'(held), 32'(TO));
    check("wd_err_set", 32'(timeout_err), 32'd1);
    step(1'b1, 4'b0001, 4'b0000);
    check("wd_served_blocks", 32'(grant), 32'd0);
    step(1'b0, 4'b0001, 4'b0000);
    step(1'b1, 4'b0001, 4'b0000);
    step(1'b1, 4'b0001, 4'b0000);
    check("wd_next_frame", 32'({grant, timeout_err}), 32'({4'b0001, 1'b1}));
`endif

    // Randomized traffic against the model.
    do_reset(1'b0);
    vcur = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 29) == 0) vcur = ~vcur;
      step(vcur, 4'($urandom), ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000);
      exp_g = (m_g >= 0) ? 4'(1 << m_g) : 4'b0000;
      check("rand_cycle", 32'({grant, frame_tick, aborted, timeout_err, frame_cnt}),
            32'({exp_g, m_tick, m_ab, m_terr, 8'(m_frame)}));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
